logic_gate_pipe: RTL
====================

LOGIC_GATE_PIPE -- requirements
Module: logic_gate_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits (legal 1..32).
REQ-002 Parameter STAGES, default 2, pipeline depth in register stages (legal 1..4).
REQ-003 Port clk  input  1  single clock, all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port in_valid  input  1  operand beat offered.
REQ-006 Port in_ready  output  1  block accepts the beat this cycle.
REQ-007 Port a  input  WIDTH  operand A.
REQ-008 Port b  input  WIDTH  operand B.
REQ-009 Port op  input  3  gate select: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT A, 7 reserved.
REQ-010 Port out_valid  output  1  result beat present.
REQ-011 Port out_ready  input  1  consumer accepts the result.
REQ-012 Port out  output  WIDTH  bitwise result.
REQ-013 Port op_err  output  1  result produced from op 7, qualified by out_valid.
REQ-014 Port txn_count  output  16  count of delivered results.

Function
REQ-015 Result is the bitwise gate of a and b per op, computed on the accepted beat.
REQ-016 Op 7 shall yield out all zeros with op_err 1; every other op yields op_err 0.
REQ-017 Pipeline advance = out_ready OR NOT out_valid; in_ready shall equal advance, combinationally.
REQ-018 Beat accepted when in_valid AND in_ready; result appears on out_valid exactly STAGES advancing cycles later.
REQ-019 With out_ready held high, throughput shall be one result per cycle, no bubbles inserted.
REQ-020 On stall (out_valid 1, out_ready 0) every stage, out, op_err and out_valid shall hold unchanged.
REQ-021 Empty stages propagate as bubbles; a bubble at the output stage shall not block acceptance.
REQ-022 txn_count increments on out_valid AND out_ready, saturates at 0xFFFF, never wraps.
REQ-023 a, b, op sampled only on acceptance; changes while in_valid is 0 or in_ready is 0 have no effect.

Reset
REQ-024 rst_n low shall immediately clear all stage valids, out_valid 0, out 0, op_err 0, txn_count 0.
REQ-025 Reset mid-operation shall discard all in-flight beats; no partial result emerges after release.
REQ-026 in_ready shall be 1 while in reset and on the first cycle after release.

Configuration
REQ-027 Macro LOGIC_GATE_PIPE_BIST_EN, when defined, adds ports bist_start (in 1), bist_busy (out 1), bist_pass (out 1).
REQ-028 With macro: FSM IDLE -> RUN on bist_start pulse while idle; RUN sweeps op 0..6 over patterns (0,0), (0,~0), (~0,0), (~0,~0) internally, in_ready 0 throughout.
REQ-029 With macro: RUN -> CHECK after 28 beats drained; CHECK compares each result to expected, bist_pass 1 if all match; CHECK -> IDLE next cycle; bist_busy 1 in RUN and CHECK; BIST results do not touch txn_count or out_valid.
REQ-030 Without macro: BIST ports and FSM absent; behaviour exactly REQ-015..026.

Verification
REQ-031 WIDTH 8, STAGES 2, a=0xF0, b=0xCC, op 0..6 back-to-back, out_ready 1 -> out 0xC0,0xFC,0x3F,0x03,0x3C,0xC3,0x0F on consecutive cycles starting 2 cycles after first accept.
REQ-032 op 7, a=0xFF, b=0xFF -> out 0x00, op_err 1; following op 0 beat -> op_err 0.
REQ-033 out_ready 0 for 5 cycles with pipe full -> in_ready 0, out stable; release -> in-order results, none lost or duplicated.
REQ-034 rst_n low mid-stream with 2 beats in flight -> out_valid 0 immediately, txn_count 0, no stale beat after release.
REQ-035 70000 delivered beats -> txn_count holds at 0xFFFF.
REQ-036 Macro defined, bist_start pulse -> bist_busy 1 for sweep, bist_pass 1, in_ready 0 during RUN, external out_valid never asserted.

Source files
------------

// File: rtl/logic_gate_pipe.sv
// Purpose : pipelined bitwise gate unit (AND/OR/NAND/NOR/XOR/XNOR/NOT A) on a valid/ready stream.
// Latency : STAGES advancing cycles from acceptance to out_valid.
// Backpr. : all stages freeze while out_valid && !out_ready; in_ready = out_ready || !out_valid.
//
// Ports   : clk, rst_n (async active-low); in_valid/in_ready with operands a, b and gate select op;
//           out_valid/out_ready with result out and op_err (op 7 seen); txn_count = delivered
//           results, saturating at 0xFFFF.
// Option  : define LOGIC_GATE_PIPE_BIST_EN to add bist_start/bist_busy/bist_pass and a built-in
//           sweep of ops 0..6 over the four all-zeros/all-ones operand patterns.
module logic_gate_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             op_err,
  output logic [15:0]      txn_count
`ifdef LOGIC_GATE_PIPE_BIST_EN
  ,
  input  logic             bist_start,
  output logic             bist_busy,
  output logic             bist_pass
`endif
);

  function automatic logic [WIDTH-1:0] gate_fn(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic [2:0]       sel);
    logic [WIDTH-1:0] r;
    r = '0;
    case (sel)
      3'd0:    r = x & y;
      3'd1:    r = x | y;
      3'd2:    r = ~(x & y);
      3'd3:    r = ~(x | y);
      3'd4:    r = x ^ y;
      3'd5:    r = ~(x ^ y);
      3'd6:    r = ~x;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] err_q, err_d;
  logic [WIDTH-1:0]  dat_q [STAGES];
  logic [WIDTH-1:0]  dat_d [STAGES];
  logic [15:0]       txn_q, txn_d;

  logic             advance;
  logic             take;
  logic             load;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [2:0]       sel_op;

  // One global enable: the pipe only stalls when a real result is waiting on the consumer.
  assign advance   = out_ready | ~out_valid;
  assign out_valid = vld_q[STAGES-1];
  assign out       = dat_q[STAGES-1];
  assign op_err    = err_q[STAGES-1];
  assign txn_count = txn_q;
  assign take      = in_valid & in_ready;

`ifdef LOGIC_GATE_PIPE_BIST_EN
  typedef enum logic [1:0] {B_IDLE, B_RUN, B_CHECK} bist_state_e;
  localparam logic [4:0] BIST_BEATS = 5'd28;

  bist_state_e       state_q, state_d;
  logic [4:0]        inj_q, inj_d, ret_q, ret_d;
  logic [2:0]        bop_q, bop_d;
  logic [1:0]        bpat_q, bpat_d;
  logic              fail_q, fail_d, pass_q, pass_d;
  // BIST beats travel beside the external valids so they never raise out_valid.
  logic [STAGES-1:0] bv_q, bv_d, bexp_q, bexp_d;
  logic              bist_inject, bist_exit, bist_bad;

  // Expected single-bit result per op, indexed by {pattern_a, pattern_b}.
  function automatic logic tt_bit(input logic [2:0] o, input logic [1:0] p);
    logic [3:0] t;
    t = 4'b0000;
    case (o)
      3'd0:    t = 4'b1000;
      3'd1:    t = 4'b1110;
      3'd2:    t = 4'b0111;
      3'd3:    t = 4'b0001;
      3'd4:    t = 4'b0110;
      3'd5:    t = 4'b1001;
      3'd6:    t = 4'b0011;
      default: t = 4'b0000;
    endcase
    return t[p];
  endfunction

  assign in_ready    = advance & (state_q == B_IDLE);
  assign bist_inject = (state_q == B_RUN) && (inj_q != BIST_BEATS) && advance;
  assign bist_exit   = bv_q[STAGES-1] & advance;
  assign bist_bad    = (dat_q[STAGES-1] != {WIDTH{bexp_q[STAGES-1]}}) | err_q[STAGES-1];
  assign bist_pass   = pass_q;
  assign load        = take | bist_inject;

  always_comb begin
    sel_a  = a;
    sel_b  = b;
    sel_op = op;
    if (bist_inject) begin
      sel_a  = {WIDTH{bpat_q[1]}};
      sel_b  = {WIDTH{bpat_q[0]}};
      sel_op = bop_q;
    end
  end

  always_comb begin
    bv_d   = bv_q;
    bexp_d = bexp_q;
    if (advance) begin
      bv_d[0]   = bist_inject;
      bexp_d[0] = bist_inject & tt_bit(bop_q, bpat_q);
      for (int i = 1; i < STAGES; i++) begin
        bv_d[i]   = bv_q[i-1];
        bexp_d[i] = bexp_q[i-1];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    inj_d     = inj_q;
    ret_d     = ret_q;
    bop_d     = bop_q;
    bpat_d    = bpat_q;
    fail_d    = fail_q;
    pass_d    = pass_q;
    bist_busy = 1'b0;
    case (state_q)
      B_IDLE: begin
        if (bist_start) begin
          state_d = B_RUN;
          inj_d   = '0;
          ret_d   = '0;
          bop_d   = '0;
          bpat_d  = '0;
          fail_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      B_RUN: begin
        bist_busy = 1'b1;
        if (bist_inject) begin
          inj_d = inj_q + 5'd1;
          if (bop_q == 3'd6) begin
            bop_d  = '0;
            bpat_d = bpat_q + 2'd1;
          end else begin
            bop_d = bop_q + 3'd1;
          end
        end
        if (bist_exit) begin
          ret_d = ret_q + 5'd1;
          if (bist_bad) fail_d = 1'b1;
        end
        if (ret_q == BIST_BEATS) state_d = B_CHECK;
      end
      B_CHECK: begin
        bist_busy = 1'b1;
        pass_d    = ~fail_q;
        state_d   = B_IDLE;
      end
      default: state_d = B_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= B_IDLE;
      inj_q   <= '0;
      ret_q   <= '0;
      bop_q   <= '0;
      bpat_q  <= '0;
      fail_q  <= 1'b0;
      pass_q  <= 1'b0;
      bv_q    <= '0;
      bexp_q  <= '0;
    end else begin
      state_q <= state_d;
      inj_q   <= inj_d;
      ret_q   <= ret_d;
      bop_q   <= bop_d;
      bpat_q  <= bpat_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
      bv_q    <= bv_d;
      bexp_q  <= bexp_d;
    end
  end
`else
  assign in_ready = advance;
  assign load     = take;
  assign sel_a    = a;
  assign sel_b    = b;
  assign sel_op   = op;
`endif

  // Empty slots carry zero data so idle outputs never reflect unaccepted operands.
  always_comb begin
    vld_d = vld_q;
    err_d = err_q;
    dat_d = dat_q;
    if (advance) begin
      vld_d[0] = take;
      dat_d[0] = load ? gate_fn(sel_a, sel_b, sel_op) : '0;
      err_d[0] = load & (sel_op == 3'd7);
      for (int i = 1; i < STAGES; i++) begin
        vld_d[i] = vld_q[i-1];
        dat_d[i] = dat_q[i-1];
        err_d[i] = err_q[i-1];
      end
    end
  end

  always_comb begin
    txn_d = txn_q;
    if (out_valid && out_ready && (txn_q != 16'hFFFF)) txn_d = txn_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      err_q <= '0;
      txn_q <= '0;
      for (int i = 0; i < STAGES; i++) dat_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      err_q <= err_d;
      txn_q <= txn_d;
      dat_q <= dat_d;
    end
  end

endmodule
